// File: rtl/div_unit_if.sv
// ============================================================================
// Module   : div_unit_if
// Brief    : Request/response bundle between the EX stage and the divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    modport master (
        output start, op, dividend, divisor, flush,
        input  busy, valid, result
    );

    modport slave (
        input  start, op, dividend, divisor, flush,
        output busy, valid, result
    );
endinterface

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Brief    : Iterative RV32M DIV/DIVU/REM/REMU, restoring shift-subtract, 32 cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit (
    input  logic            clk,
    input  logic            rst,
    div_unit_if.slave       div_bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [31:0] r_result;
    logic        r_is_rem;
    logic        r_qneg;
    logic        r_rneg;
    logic        w_busy;
    logic        w_valid;

    // Acceptance-time operand conditioning and special-case detection
    logic        w_accept;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div0;
    logic        w_ovf;
    logic        w_special;
    logic [31:0] w_special_res;

    assign w_accept  = (r_state == c_IDLE) && div_bus.start && !div_bus.flush;
    assign w_signed  = !div_bus.op[0];
    assign w_a_neg   = w_signed && div_bus.dividend[31];
    assign w_b_neg   = w_signed && div_bus.divisor[31];
    assign w_a_mag   = w_a_neg ? (32'd0 - div_bus.dividend) : div_bus.dividend;
    assign w_b_mag   = w_b_neg ? (32'd0 - div_bus.divisor)  : div_bus.divisor;
    assign w_div0    = (div_bus.divisor == 32'd0);
    assign w_ovf     = w_signed && (div_bus.dividend == 32'h8000_0000)
                                && (div_bus.divisor  == 32'hFFFF_FFFF);
    assign w_special = w_div0 || w_ovf;

    // Divide-by-zero returns the raw dividend as remainder, not its magnitude
    always_comb begin
        w_special_res = 32'd0;
        if (div_bus.op[1]) begin
            w_special_res = w_div0 ? div_bus.dividend : 32'd0;
        end else begin
            w_special_res = w_div0 ? 32'hFFFF_FFFF : 32'h8000_0000;
        end
    end

    // One restoring iteration; bit 32 of the shifted remainder implies trial >= 0
    logic [32:0] w_rem_sh;
    logic [32:0] w_trial;
    logic        w_ge;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic        w_last;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_final;

    assign w_rem_sh  = {r_rem, r_quo[31]};
    assign w_trial   = w_rem_sh - {1'b0, r_dvs};
    assign w_ge      = w_rem_sh[32] || !w_trial[32];
    assign w_rem_nx  = w_ge ? w_trial[31:0] : w_rem_sh[31:0];
    assign w_quo_nx  = {r_quo[30:0], w_ge};
    assign w_last    = (r_cnt == 6'd31);
    assign w_quo_fix = r_qneg ? (32'd0 - w_quo_nx) : w_quo_nx;
    assign w_rem_fix = r_rneg ? (32'd0 - w_rem_nx) : w_rem_nx;
    assign w_final   = r_is_rem ? w_rem_fix : w_quo_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_special ? c_DONE : c_CALC;
                end
            end
            c_CALC: begin
                w_busy = 1'b1;
                if (div_bus.flush) begin
                    w_next_state = c_IDLE;
                end else if (w_last) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                w_busy       = 1'b1;
                w_valid      = !div_bus.flush;
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 6'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_dvs    <= 32'd0;
            r_result <= 32'd0;
            r_is_rem <= 1'b0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_is_rem <= div_bus.op[1];
                        r_qneg   <= w_a_neg ^ w_b_neg;
                        r_rneg   <= w_a_neg;
                        r_dvs    <= w_b_mag;
                        r_rem    <= 32'd0;
                        r_quo    <= w_a_mag;
                        r_cnt    <= 6'd0;
                        if (w_special) begin
                            r_result <= w_special_res;
                        end
                    end
                end
                c_CALC: begin
                    if (div_bus.flush) begin
                        r_cnt <= 6'd0;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= w_last ? 6'd0 : (r_cnt + 6'd1);
                        if (w_last) begin
                            r_result <= w_final;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign div_bus.busy   = w_busy;
    assign div_bus.valid  = w_valid;
    assign div_bus.result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module   : tb_div_unit
// Brief    : Directed self-checking bench for div_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    div_unit_if dif ();

    div_unit dut (
        .clk     (clk),
        .rst     (rst),
        .div_bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issue one request, wait for valid (bounded), check latency/result/busy.
    // A nonzero poke cycle pulses an unrelated start while the unit is busy.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input int poke);
        int  n;
        int  busy_bad;
        bit  seen;
        @(negedge clk);
        dif.start = 1'b1; dif.op = o; dif.dividend = a; dif.divisor = b;
        @(posedge clk);
        #1 dif.start = 1'b0; dif.dividend = 32'hDEAD_BEEF; dif.divisor = 32'h0000_0003;
        n = 0; busy_bad = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (dif.busy !== 1'b1) busy_bad++;
            if (dif.valid === 1'b1) begin
                seen = 1'b1;
            end else if (n == poke) begin
                dif.start = 1'b1; dif.op = ~o; dif.dividend = 32'd7; dif.divisor = 32'd3;
                @(posedge clk);
                #1 dif.start = 1'b0;
            end
        end
        check({tag, "_latency"}, n, lat);
        check({tag, "_result"}, dif.result, exp);
        check({tag, "_busy_held"}, busy_bad, 0);
        @(negedge clk);
        check({tag, "_idle_after"}, {30'd0, dif.busy, dif.valid}, 32'd0);
    endtask

    initial begin : stim
        bit seen;
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1;
        dif.start = 1'b0; dif.op = 2'b00; dif.dividend = 32'd0; dif.divisor = 32'd0;
        dif.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy",   dif.busy,   0);
        check("reset_valid",  dif.valid,  0);
        check("reset_result", dif.result, 32'h0);

        do_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFD, 33, 0);
        do_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF, 33, 0);
        do_op("divu_max16", 2'b01, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33, 0);
        do_op("remu_max16", 2'b11, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 33, 0);
        do_op("div_20_m3",  2'b00, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33, 0);
        do_op("rem_20_m3",  2'b10, 32'd20, 32'hFFFF_FFFD, 32'h0000_0002, 33, 0);
        do_op("div_5_0",    2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        do_op("rem_5_0",    2'b10, 32'd5, 32'd0, 32'h0000_0005, 1, 0);
        do_op("remu_m5_0",  2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 0);
        do_op("rem_m5_0",   2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 0);
        do_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        do_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
        do_op("divu_poke",  2'b01, 32'd100, 32'd7, 32'd14, 33, 5);

        // Flush mid-calculation: no valid, result keeps its previous value
        @(negedge clk);
        dif.start = 1'b1; dif.op = 2'b01; dif.dividend = 32'd100; dif.divisor = 32'd7;
        @(posedge clk);
        #1 dif.start = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (dif.valid === 1'b1) seen = 1'b1;
        end
        dif.flush = 1'b1;
        @(posedge clk);
        #1 dif.flush = 1'b0;
        @(negedge clk);
        check("flush_busy", dif.busy, 0);
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (dif.valid === 1'b1) seen = 1'b1;
        end
        check("flush_no_valid", seen, 0);
        check("flush_result_held", dif.result, 32'd14);
        do_op("divu_after_flush", 2'b01, 32'd100, 32'd7, 32'd14, 33, 0);

        // Flush and start together in IDLE: nothing accepted
        @(negedge clk);
        dif.start = 1'b1; dif.flush = 1'b1; dif.op = 2'b01; dif.dividend = 32'd9; dif.divisor = 32'd3;
        @(posedge clk);
        #1 dif.start = 1'b0; dif.flush = 1'b0;
        @(negedge clk);
        check("flush_start_idle", {30'd0, dif.busy, dif.valid}, 32'd0);

        // Start during DONE is ignored
        @(negedge clk);
        dif.start = 1'b1; dif.op = 2'b00; dif.dividend = 32'd5; dif.divisor = 32'd0;
        @(posedge clk);
        #1 dif.start = 1'b0;
        @(negedge clk);
        check("done_valid", dif.valid, 1);
        dif.start = 1'b1; dif.op = 2'b01; dif.dividend = 32'd100; dif.divisor = 32'd7;
        @(posedge clk);
        #1 dif.start = 1'b0;
        @(negedge clk);
        check("start_in_done_ignored", dif.busy, 0);

        // Flush in DONE gates valid
        @(negedge clk);
        dif.start = 1'b1; dif.op = 2'b10; dif.dividend = 32'd5; dif.divisor = 32'd0;
        @(posedge clk);
        #1 dif.start = 1'b0;
        @(negedge clk);
        dif.flush = 1'b1;
        #1 check("flush_done_valid", dif.valid, 0);
        @(posedge clk);
        #1 dif.flush = 1'b0;
        @(negedge clk);
        check("flush_done_idle", dif.busy, 0);

        // Reset aborts an in-flight op; a start pulsed while busy is ignored
        do_op("divu_before_rst", 2'b01, 32'd100, 32'd7, 32'd14, 33, 0);
        @(negedge clk);
        dif.start = 1'b1; dif.op = 2'b00; dif.dividend = 32'd1000; dif.divisor = 32'd3;
        @(posedge clk);
        #1 dif.start = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (dif.valid === 1'b1) seen = 1'b1;
            if (i == 5) dif.start = 1'b1;
            if (i == 6) dif.start = 1'b0;
        end
        dif.start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy",   dif.busy,   0);
        check("rst_valid",  dif.valid,  0);
        check("rst_result", dif.result, 32'h0);
        check("rst_no_early_valid", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
